// File: rtl/req_encoder_32_5.sv
// rtl/req_encoder_32_5.sv - serial multi-hot to index encoder, lowest set bit first
module req_encoder_32_5 #(
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [WIDTH-1:0]           req_vec,
    output logic                       in_ready,
    input  logic                       abort,
    output logic                       out_valid,
    output logic [$clog2(WIDTH)-1:0]   out_idx,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH):0]     pending_cnt,
    output logic                       done
);

    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_pending;
    logic [IDX_W:0]     r_cnt;
    logic               r_done;
    logic [WIDTH-1:0]   w_lsb;
    logic [WIDTH-1:0]   w_remain;
    logic [IDX_W-1:0]   w_idx;
    logic               w_xfer;
    logic               w_last;
    logic               w_load_nz;
    logic               w_load_z;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Two's-complement trick isolates the lowest set bit as a one-hot mask.
    assign w_lsb    = r_pending & (~r_pending + WIDTH'(1));
    assign w_remain = r_pending & ~w_lsb;

    always_comb begin
        w_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_idx     = '0;
        w_xfer      = 1'b0;
        w_last      = 1'b0;
        w_load_nz   = 1'b0;
        w_load_z    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (load && !abort) begin
                    w_load_nz = (req_vec != '0);
                    w_load_z  = (req_vec == '0);
                    if (req_vec != '0) begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                out_valid = 1'b1;
                out_idx   = w_idx;
                w_xfer    = out_ready;
                w_last    = out_ready && (w_remain == '0);
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort wins over load and transfer, and never produces a done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else if (abort) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_load_z || w_last;
            if (w_load_nz) begin
                r_pending <= req_vec;
                r_cnt     <= popcount(req_vec);
            end else if (w_xfer) begin
                r_pending <= w_remain;
                r_cnt     <= r_cnt - (IDX_W+1)'(1);
            end
        end
    end

    assign pending_cnt = r_cnt;
    assign done        = r_done;

endmodule

// File: tb/tb_req_encoder_32_5.sv
// tb/tb_req_encoder_32_5.sv - directed self-checking bench for req_encoder_32_5
module tb_req_encoder_32_5;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [31:0] req_vec;
    logic        in_ready;
    logic        abort;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic        out_ready;
    logic [5:0]  pending_cnt;
    logic        done;

    int n_cmp;
    int n_err;
    int done_seen;

    req_encoder_32_5 #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .req_vec     (req_vec),
        .in_ready    (in_ready),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_ready   (out_ready),
        .pending_cnt (pending_cnt),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        done_seen = 0;
        reset_n   = 1'b0;
        load      = 1'b0;
        req_vec   = 32'h0;
        abort     = 1'b0;
        out_ready = 1'b0;

        step();
        step();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_idx", {27'b0, out_idx}, 32'd0);
        check("rst_cnt", {26'b0, pending_cnt}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        reset_n = 1'b1;
        step();

        // 0x8000_0005 -> 0, 2, 31
        load = 1'b1; req_vec = 32'h8000_0005; out_ready = 1'b1;
        step();
        load = 1'b0;
        check("t1_in_ready_busy", {31'b0, in_ready}, 32'd0);
        check("t1_valid0", {31'b0, out_valid}, 32'd1);
        check("t1_idx0", {27'b0, out_idx}, 32'd0);
        check("t1_cnt0", {26'b0, pending_cnt}, 32'd3);
        step();
        check("t1_idx1", {27'b0, out_idx}, 32'd2);
        check("t1_cnt1", {26'b0, pending_cnt}, 32'd2);
        step();
        check("t1_idx2", {27'b0, out_idx}, 32'd31);
        check("t1_cnt2", {26'b0, pending_cnt}, 32'd1);
        check("t1_done_early", {31'b0, done}, 32'd0);
        step();
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_valid_end", {31'b0, out_valid}, 32'd0);
        check("t1_cnt_end", {26'b0, pending_cnt}, 32'd0);
        step();
        check("t1_done_clr", {31'b0, done}, 32'd0);

        // all ones -> 0..31
        load = 1'b1; req_vec = 32'hFFFF_FFFF;
        step();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t2_idx%0d", i), {27'b0, out_idx}, i);
            check($sformatf("t2_cnt%0d", i), {26'b0, pending_cnt}, 32 - i);
            if (done) done_seen++;
            step();
        end
        check("t2_done_in_busy", done_seen, 32'd0);
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("t2_done_clr", {31'b0, done}, 32'd0);

        // stall on single bit 4
        out_ready = 1'b0;
        load = 1'b1; req_vec = 32'h0000_0010;
        step();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_stall_valid%0d", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("t3_stall_idx%0d", k), {27'b0, out_idx}, 32'd4);
            check($sformatf("t3_stall_cnt%0d", k), {26'b0, pending_cnt}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        check("t3_idx_ready", {27'b0, out_idx}, 32'd4);
        step();
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_valid_end", {31'b0, out_valid}, 32'd0);
        step();

        // zero vector
        load = 1'b1; req_vec = 32'h0;
        step();
        load = 1'b0;
        check("t4_valid", {31'b0, out_valid}, 32'd0);
        check("t4_done", {31'b0, done}, 32'd1);
        check("t4_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("t4_done_clr", {31'b0, done}, 32'd0);

        // abort with simultaneous transfer, load during busy ignored
        load = 1'b1; req_vec = 32'h0000_00F0; out_ready = 1'b1;
        step();
        check("t5_idx4", {27'b0, out_idx}, 32'd4);
        check("t5_cnt4", {26'b0, pending_cnt}, 32'd4);
        req_vec = 32'hFFFF_FFFF;
        step();
        load = 1'b0;
        check("t5_idx5", {27'b0, out_idx}, 32'd5);
        check("t5_cnt_load_ignored", {26'b0, pending_cnt}, 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_valid", {31'b0, out_valid}, 32'd0);
        check("t5_abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("t5_abort_cnt", {26'b0, pending_cnt}, 32'd0);
        check("t5_abort_done", {31'b0, done}, 32'd0);
        step();
        check("t5_abort_done2", {31'b0, done}, 32'd0);
        check("t5_abort_valid2", {31'b0, out_valid}, 32'd0);

        // async reset mid-busy
        out_ready = 1'b0;
        load = 1'b1; req_vec = 32'h0001_0001;
        step();
        load = 1'b0;
        check("t6_valid_pre", {31'b0, out_valid}, 32'd1);
        check("t6_cnt_pre", {26'b0, pending_cnt}, 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, out_valid}, 32'd0);
        check("t6_rst_cnt", {26'b0, pending_cnt}, 32'd0);
        check("t6_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("t6_rst_idx", {27'b0, out_idx}, 32'd0);
        step();
        check("t6_rst_done", {31'b0, done}, 32'd0);
        reset_n = 1'b1;
        step();
        check("t6_post_valid", {31'b0, out_valid}, 32'd0);
        check("t6_post_done", {31'b0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/req_encoder_32_5.md
Name: req_encoder_32_5

Overview:
- Sequential 32-to-5 request encoder: the inverse of the 5-to-32 decoder used for register-file write-enable selection.
- Captures a 32-bit multi-hot request vector and serially emits the 5-bit index of every set bit, lowest index first, over a valid/ready handshake.
- Used wherever a one-hot or multi-hot select vector must be turned back into register numbers, e.g. pending-write scoreboard drain or multi-register transfer sequencing.

Parameters:
- WIDTH, 32, request vector width; must be a power of 2, range 2..32.
- IDX_W, $clog2(WIDTH) = 5, index width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  capture req_vec; honoured only when in_ready=1.
- req_vec  input  WIDTH  request vector to encode.
- in_ready  output  1  block is idle and accepts load.
- abort  input  1  discard all pending requests.
- out_valid  output  1  out_idx holds a valid index.
- out_idx  output  IDX_W  index of the lowest pending set bit.
- out_ready  input  1  consumer accepts out_idx this cycle.
- pending_cnt  output  IDX_W+1  number of set bits still pending (0..WIDTH).
- done  output  1  one-cycle pulse when the last index is accepted, or when a zero vector is loaded.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, pending=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, pending_cnt=0, done=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On load=1 with req_vec!=0: pending<=req_vec, go to BUSY.
  - On load=1 with req_vec==0: stay IDLE, done=1 next cycle.
- State BUSY:
  - in_ready=0 and load is ignored.
  - out_valid=1.
  - out_idx = index of the lowest set bit of the pending register. Combinational from registered pending, so valid appears 1 cycle after the load edge.
- Transfer (out_valid & out_ready):
  - Clears pending[out_idx]; pending_cnt decrements.
  - If that was the last bit: go to IDLE and pulse done for 1 cycle; in_ready=1 in that same cycle.
- Back-to-back: out_ready held high yields one index per cycle. A vector with N bits set takes exactly N cycles in BUSY.
- Stall: out_ready=0 holds out_idx and out_valid stable, and pending is unchanged.
- pending_cnt:
  - Registered popcount of pending; updated in the same edge as pending.
  - Equals WIDTH (6'd32) for an all-ones load.
- out_idx when out_valid=0: driven 0.
- abort=1 (any state):
  - Next edge: pending<=0, state<=IDLE, done stays 0.
  - Takes priority over load and over a simultaneous transfer. The transferred index counts as consumed, but no done pulse.
- Bit 31 / bit 0 edge cases: index 31 encodes as 5'b11111 and bit 0 as 5'b00000. Both must be emitted, not mistaken for the empty case.
- Reset asserted mid-BUSY: all state is cleared immediately and no done pulse is produced.

Test Plan:
- Reset then load req_vec=32'h8000_0005 -> out_idx sequence 0, 2, 31 on consecutive cycles with out_ready=1; pending_cnt 3, 2, 1; done pulses in the cycle after idx 31 is accepted; in_ready=1 again.
- load 32'hFFFF_FFFF, out_ready=1 -> indices 0..31 in order over 32 cycles; pending_cnt starts at 32; exactly one done pulse.
- load 32'h0000_0010, out_ready=0 for 5 cycles then 1 -> out_idx=4 held stable with out_valid=1 throughout the stall; accepted on the first ready cycle.
- load 32'h0 -> no out_valid, done pulse one cycle later, in_ready stays 1.
- load 32'h0000_00F0, accept idx 4, then assert abort together with out_ready -> state IDLE next cycle, pending_cnt=0, no done; a load asserted during BUSY is ignored.
- Assert reset_n=0 asynchronously mid-sequence after load 32'h0001_0001 -> out_valid=0 and pending_cnt=0 immediately, without waiting for a clock edge.
